// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the execute stage: opcodes, function codes,
// multiply/divide FSM encodings and the EX/MEM register layout.
package ex_stage_pkg;

   localparam int DATA_W = 16;
   localparam int RA_W   = 4;
   localparam int CNT_W  = $clog2(DATA_W);

   localparam logic [RA_W-1:0] OP_RTYPE = 4'b0000;
   localparam logic [RA_W-1:0] OP_LW    = 4'b1000;
   localparam logic [RA_W-1:0] OP_SW    = 4'b1011;

   localparam logic [RA_W-1:0] FN_ADD = 4'h0;
   localparam logic [RA_W-1:0] FN_SUB = 4'h1;
   localparam logic [RA_W-1:0] FN_AND = 4'h2;
   localparam logic [RA_W-1:0] FN_OR  = 4'h3;
   localparam logic [RA_W-1:0] FN_MUL = 4'h4;
   localparam logic [RA_W-1:0] FN_DIV = 4'h5;
   localparam logic [RA_W-1:0] FN_SLL = 4'h8;
   localparam logic [RA_W-1:0] FN_SRL = 4'h9;
   localparam logic [RA_W-1:0] FN_ROL = 4'hA;
   localparam logic [RA_W-1:0] FN_ROR = 4'hB;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] r0_result;
      logic [DATA_W-1:0] store_data;
      logic [RA_W-1:0]   ra1;
      logic              reg_write;
      logic              r0_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_source;
      logic              div_zero;
   } ex_mem_t;

   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? -v : v;
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative signed multiply / divide: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, sign applied combinationally in DONE.
//
// state | meaning
// IDLE  | waiting for start; operands latched when it arrives
// BUSY  | DATA_W iteration steps, counter 0..DATA_W-1
// DONE  | signed result valid on lo/hi/dz for one cycle
module ex_muldiv
   import ex_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              start,
   input  logic              op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] hi,
   output logic              dz
);

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                op_q, op_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic                dz_q, dz_d;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_sh;
   logic [2*DATA_W-1:0] prod_s;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_sh  = {hi_q, lo_q[DATA_W-1]};
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_BUSY;
               cnt_d   = '0;
               op_d    = op;
               neg_d   = a[DATA_W-1] ^ b[DATA_W-1];
               rneg_d  = a[DATA_W-1];
               dz_d    = op && (b == '0);
               hi_d    = '0;
               // opnd is the multiplicand for MUL and the divisor for DIV
               opnd_d  = op ? abs_val(b) : abs_val(a);
               lo_d    = op ? abs_val(a) : abs_val(b);
            end
         end
         ST_BUSY: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (op_q) begin
                  if (div_sh >= {1'b0, opnd_q}) begin
                     hi_d = div_sh[DATA_W-1:0] - opnd_q;
                     lo_d = {lo_q[DATA_W-2:0], 1'b1};
                  end else begin
                     hi_d = div_sh[DATA_W-1:0];
                     lo_d = {lo_q[DATA_W-2:0], 1'b0};
                  end
               end else begin
                  hi_d = mul_sum[DATA_W:1];
                  lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W-1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      lo     = prod_s[DATA_W-1:0];
      hi     = prod_s[2*DATA_W-1:DATA_W];
      if (op_q) begin
         // divisor zero: all-ones quotient, dividend (still held upstream) as remainder
         if (dz_q) begin
            lo = '1;
            hi = a;
         end else begin
            lo = neg_q ? -lo_q : lo_q;
            hi = rneg_q ? -hi_q : hi_q;
         end
      end
   end

   assign busy = (state_q == ST_BUSY);
   assign done = (state_q == ST_DONE);
   assign dz   = dz_q & op_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand mux, single-cycle ALU, load/store address generation,
// iterative MUL/DIV with upstream stall, and the EX/MEM pipeline register.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_ex,
   input  logic [DATA_W-1:0] RD1_EX,
   input  logic [DATA_W-1:0] RD2_EX,
   input  logic [DATA_W-1:0] SE_offset_EX,
   input  logic [RA_W-1:0]   opcode_EX,
   input  logic [RA_W-1:0]   RA1_EX,
   input  logic [RA_W-1:0]   RA2_EX,
   input  logic [RA_W-1:0]   FN_offset_EX,
   input  logic              regWrite_EX,
   input  logic              r0Write_EX,
   input  logic              alusource_EX,
   input  logic              memRead_EX,
   input  logic              memWrite_EX,
   input  logic              memSource_EX,
   output logic              stall_ex,
   output logic [DATA_W-1:0] alu_result_MEM,
   output logic [DATA_W-1:0] r0_result_MEM,
   output logic [DATA_W-1:0] store_data_MEM,
   output logic [RA_W-1:0]   RA1_MEM,
   output logic              regWrite_MEM,
   output logic              r0Write_MEM,
   output logic              memRead_MEM,
   output logic              memWrite_MEM,
   output logic              memSource_MEM,
   output logic              div_zero_MEM
);

   logic [DATA_W-1:0]   op_a, op_b, alu_res;
   logic [2*DATA_W-1:0] rot_l, rot_r;
   logic                is_rtype, is_md, fn_bad;
   logic                md_start, md_busy, md_done, md_dz;
   logic [DATA_W-1:0]   md_lo, md_hi;
   ex_mem_t             ex_mem_q, ex_mem_d;

   always_comb begin
      op_a     = alusource_EX ? RD2_EX : RD1_EX;
      op_b     = alusource_EX ? SE_offset_EX : RD2_EX;
      rot_l    = {op_a, op_a} << RA2_EX;
      rot_r    = {op_a, op_a} >> RA2_EX;
      is_rtype = (opcode_EX == OP_RTYPE);
      is_md    = is_rtype && (FN_offset_EX == FN_MUL || FN_offset_EX == FN_DIV);
      fn_bad   = 1'b0;
      alu_res  = op_a + op_b;
      if (is_rtype) begin
         case (FN_offset_EX)
            FN_ADD:  alu_res = op_a + op_b;
            FN_SUB:  alu_res = op_a - op_b;
            FN_AND:  alu_res = op_a & op_b;
            FN_OR:   alu_res = op_a | op_b;
            FN_MUL:  alu_res = '0;
            FN_DIV:  alu_res = '0;
            FN_SLL:  alu_res = op_a << RA2_EX;
            FN_SRL:  alu_res = op_a >> RA2_EX;
            FN_ROL:  alu_res = rot_l[2*DATA_W-1:DATA_W];
            FN_ROR:  alu_res = rot_r[DATA_W-1:0];
            default: begin
               alu_res = '0;
               fn_bad  = 1'b1;
            end
         endcase
      end else if (opcode_EX == OP_LW || opcode_EX == OP_SW) begin
         alu_res = RD2_EX + SE_offset_EX;
      end
   end

   assign md_start = is_md && !flush_ex && !reset && !md_busy && !md_done;
   assign stall_ex = !reset && (md_start || md_busy);

   ex_muldiv u_muldiv (
      .clk   (clk),
      .reset (reset),
      .flush (flush_ex),
      .start (md_start),
      .op    (FN_offset_EX == FN_DIV),
      .a     (op_a),
      .b     (op_b),
      .busy  (md_busy),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi),
      .dz    (md_dz)
   );

   always_comb begin
      ex_mem_d = '0;
      if (!flush_ex && !stall_ex) begin
         ex_mem_d.store_data = RD1_EX;
         ex_mem_d.ra1        = RA1_EX;
         ex_mem_d.reg_write  = regWrite_EX & ~fn_bad;
         ex_mem_d.r0_write   = r0Write_EX & ~fn_bad;
         ex_mem_d.mem_read   = memRead_EX & ~fn_bad;
         ex_mem_d.mem_write  = memWrite_EX & ~fn_bad;
         ex_mem_d.mem_source = memSource_EX;
         if (md_done) begin
            ex_mem_d.alu_result = md_lo;
            ex_mem_d.r0_result  = md_hi;
            ex_mem_d.div_zero   = md_dz;
         end else begin
            ex_mem_d.alu_result = alu_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ex_mem_q <= '0;
      else       ex_mem_q <= ex_mem_d;
   end

   assign alu_result_MEM = ex_mem_q.alu_result;
   assign r0_result_MEM  = ex_mem_q.r0_result;
   assign store_data_MEM = ex_mem_q.store_data;
   assign RA1_MEM        = ex_mem_q.ra1;
   assign regWrite_MEM   = ex_mem_q.reg_write;
   assign r0Write_MEM    = ex_mem_q.r0_write;
   assign memRead_MEM    = ex_mem_q.mem_read;
   assign memWrite_MEM   = ex_mem_q.mem_write;
   assign memSource_MEM  = ex_mem_q.mem_source;
   assign div_zero_MEM   = ex_mem_q.div_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed instructions, an arithmetic
// reference model of the EX/MEM contents, and a per-cycle compare process.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset, flush_ex;
   logic [15:0] RD1_EX, RD2_EX, SE_offset_EX;
   logic [3:0]  opcode_EX, RA1_EX, RA2_EX, FN_offset_EX;
   logic        regWrite_EX, r0Write_EX, alusource_EX, memRead_EX, memWrite_EX, memSource_EX;
   logic        stall_ex;
   logic [15:0] alu_result_MEM, r0_result_MEM, store_data_MEM;
   logic [3:0]  RA1_MEM;
   logic        regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM, div_zero_MEM;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .flush_ex(flush_ex),
      .RD1_EX(RD1_EX), .RD2_EX(RD2_EX), .SE_offset_EX(SE_offset_EX),
      .opcode_EX(opcode_EX), .RA1_EX(RA1_EX), .RA2_EX(RA2_EX), .FN_offset_EX(FN_offset_EX),
      .regWrite_EX(regWrite_EX), .r0Write_EX(r0Write_EX), .alusource_EX(alusource_EX),
      .memRead_EX(memRead_EX), .memWrite_EX(memWrite_EX), .memSource_EX(memSource_EX),
      .stall_ex(stall_ex),
      .alu_result_MEM(alu_result_MEM), .r0_result_MEM(r0_result_MEM),
      .store_data_MEM(store_data_MEM), .RA1_MEM(RA1_MEM),
      .regWrite_MEM(regWrite_MEM), .r0Write_MEM(r0Write_MEM), .memRead_MEM(memRead_MEM),
      .memWrite_MEM(memWrite_MEM), .memSource_MEM(memSource_MEM), .div_zero_MEM(div_zero_MEM)
   );

   typedef struct {
      logic [15:0] rd1, rd2, se;
      logic [3:0]  opc, ra1, ra2, fn;
      logic        rw, r0w, als, mr, mw, ms;
   } instr_t;

   typedef struct {
      logic [15:0] alu, r0, sd;
      logic [3:0]  ra1;
      logic        rw, r0w, mr, mw, ms, dz;
   } exp_t;

   exp_t exp_c;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   function automatic instr_t mk(logic [3:0] opc, logic [3:0] fn, logic [3:0] ra1, logic [3:0] ra2,
                                 logic [15:0] rd1, logic [15:0] rd2, logic [15:0] se,
                                 logic als, logic rw, logic r0w, logic mr, logic mw, logic ms);
      instr_t i;
      i.opc = opc; i.fn = fn; i.ra1 = ra1; i.ra2 = ra2;
      i.rd1 = rd1; i.rd2 = rd2; i.se = se;
      i.als = als; i.rw = rw; i.r0w = r0w; i.mr = mr; i.mw = mw; i.ms = ms;
      return i;
   endfunction

   function automatic exp_t bubble();
      exp_t m;
      m.alu = '0; m.r0 = '0; m.sd = '0; m.ra1 = '0;
      m.rw = 0; m.r0w = 0; m.mr = 0; m.mw = 0; m.ms = 0; m.dz = 0;
      return m;
   endfunction

   // What EX/MEM must hold once the instruction completes, from signed arithmetic.
   function automatic exp_t model(instr_t i);
      exp_t        m;
      logic [15:0] a, b;
      logic [31:0] pv;
      int          sa, sb;
      a = i.als ? i.rd2 : i.rd1;
      b = i.als ? i.se  : i.rd2;
      sa = int'($signed(a));
      sb = int'($signed(b));
      m.alu = a + b; m.r0 = '0; m.sd = i.rd1; m.ra1 = i.ra1;
      m.rw = i.rw; m.r0w = i.r0w; m.mr = i.mr; m.mw = i.mw; m.ms = i.ms; m.dz = 0;
      if (i.opc == 4'b1000 || i.opc == 4'b1011) begin
         m.alu = i.rd2 + i.se;
      end else if (i.opc == 4'b0000) begin
         case (i.fn)
            4'h0: m.alu = a + b;
            4'h1: m.alu = a - b;
            4'h2: m.alu = a & b;
            4'h3: m.alu = a | b;
            4'h4: begin
               pv = sa * sb;
               m.alu = pv[15:0];
               m.r0  = pv[31:16];
            end
            4'h5: begin
               if (b == 16'h0) begin
                  m.alu = 16'hFFFF; m.r0 = a; m.dz = 1;
               end else begin
                  pv = sa / sb; m.alu = pv[15:0];
                  pv = sa % sb; m.r0  = pv[15:0];
               end
            end
            4'h8: m.alu = a << i.ra2;
            4'h9: m.alu = a >> i.ra2;
            4'hA: for (int k = 0; k < 16; k++) m.alu[(k + int'(i.ra2)) % 16] = a[k];
            4'hB: for (int k = 0; k < 16; k++) m.alu[k] = a[(k + int'(i.ra2)) % 16];
            default: begin
               m.alu = '0; m.rw = 0; m.r0w = 0; m.mr = 0; m.mw = 0;
            end
         endcase
      end
      return m;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (alu_result_MEM !== exp_c.alu || r0_result_MEM !== exp_c.r0 ||
             store_data_MEM !== exp_c.sd || RA1_MEM !== exp_c.ra1 ||
             regWrite_MEM !== exp_c.rw || r0Write_MEM !== exp_c.r0w ||
             memRead_MEM !== exp_c.mr || memWrite_MEM !== exp_c.mw ||
             memSource_MEM !== exp_c.ms || div_zero_MEM !== exp_c.dz) begin
            failures++;
            $display("FAIL exmem t=%0t got alu=%h r0=%h sd=%h ra1=%h rw=%b r0w=%b mr=%b mw=%b ms=%b dz=%b want alu=%h r0=%h sd=%h ra1=%h rw=%b r0w=%b mr=%b mw=%b ms=%b dz=%b",
                     $time, alu_result_MEM, r0_result_MEM, store_data_MEM, RA1_MEM,
                     regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM, div_zero_MEM,
                     exp_c.alu, exp_c.r0, exp_c.sd, exp_c.ra1, exp_c.rw, exp_c.r0w,
                     exp_c.mr, exp_c.mw, exp_c.ms, exp_c.dz);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   task automatic apply(input instr_t i);
      RD1_EX = i.rd1; RD2_EX = i.rd2; SE_offset_EX = i.se;
      opcode_EX = i.opc; RA1_EX = i.ra1; RA2_EX = i.ra2; FN_offset_EX = i.fn;
      regWrite_EX = i.rw; r0Write_EX = i.r0w; alusource_EX = i.als;
      memRead_EX = i.mr; memWrite_EX = i.mw; memSource_EX = i.ms;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the capture edge.
   task automatic exec(input instr_t i, input int want_stall, input string nm);
      int n = 0;
      apply(i);
      #1;
      while (stall_ex === 1'b1 && n < 40) begin
         n++;
         @(posedge clk); exp_c = bubble(); #1;
      end
      chk({nm, " stall_cycles"}, n, want_stall);
      @(posedge clk); exp_c = model(i); #1;
   endtask

   task automatic flush_idle(input instr_t i, input string nm);
      apply(i);
      flush_ex = 1'b1;
      #1;
      chk({nm, " stall"}, stall_ex, 0);
      @(posedge clk); exp_c = bubble(); #1;
      flush_ex = 1'b0;
   endtask

   task automatic abort_busy(input instr_t i, input bit use_reset, input string nm);
      apply(i);
      #1;
      repeat (5) begin
         @(posedge clk); exp_c = bubble(); #1;
      end
      chk({nm, " stall_busy5"}, stall_ex, 1);
      if (use_reset) reset = 1'b1;
      else           flush_ex = 1'b1;
      @(posedge clk); exp_c = bubble(); #1;
      reset = 1'b0;
      flush_ex = 1'b0;
      apply(mk(4'h1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0));
      #1;
      chk({nm, " stall_after"}, stall_ex, 0);
      chk({nm, " writes"}, {regWrite_MEM, r0Write_MEM}, 0);
   endtask

   task automatic flush_done(input instr_t i, input string nm);
      int n = 0;
      apply(i);
      #1;
      while (stall_ex === 1'b1 && n < 40) begin
         n++;
         @(posedge clk); exp_c = bubble(); #1;
      end
      chk({nm, " stall_cycles"}, n, 17);
      flush_ex = 1'b1;
      @(posedge clk); exp_c = bubble(); #1;
      flush_ex = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t nop, mul1;
      nop  = mk(4'h1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
      mul1 = mk(4'h0, 4'h4, 4'h2, 4'h0, 16'hFFFD, 16'h0005, 16'h0, 0, 1, 1, 0, 0, 0);
      exp_c = bubble();

      reset = 1'b1;
      flush_ex = 1'(($urandom));
      RD1_EX = 16'($urandom); RD2_EX = 16'($urandom); SE_offset_EX = 16'($urandom);
      opcode_EX = 4'h0; FN_offset_EX = 4'h4; RA1_EX = 4'($urandom); RA2_EX = 4'($urandom);
      regWrite_EX = 1; r0Write_EX = 1; alusource_EX = 1'($urandom);
      memRead_EX = 1; memWrite_EX = 1; memSource_EX = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset stall", stall_ex, 0);
      chk("reset alu", alu_result_MEM, 0);
      chk("reset ctl", {regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM, div_zero_MEM}, 0);
      chk_en = 1'b1;
      reset = 1'b0;
      flush_ex = 1'b0;
      exec(nop, 0, "nop");

      exec(mk(4'h0, 4'h0, 4'h3, 4'h0, 16'h7FFF, 16'h0001, 16'h0, 0, 1, 0, 0, 0, 0), 0, "add");
      chk("add alu", alu_result_MEM, 16'h8000);
      chk("add ra1", RA1_MEM, 4'd3);
      chk("add rw", regWrite_MEM, 1);

      exec(mk(4'h8, 4'h0, 4'h5, 4'h0, 16'h1234, 16'h0010, 16'hFFFE, 1, 1, 0, 1, 0, 1), 0, "lw");
      chk("lw alu", alu_result_MEM, 16'h000E);
      chk("lw ctl", {memRead_MEM, regWrite_MEM}, 2'b11);

      exec(mk(4'hB, 4'h0, 4'h6, 4'h0, 16'hABCD, 16'h0100, 16'h0004, 1, 0, 0, 0, 1, 0), 0, "sw");
      chk("sw alu", alu_result_MEM, 16'h0104);
      chk("sw data", store_data_MEM, 16'hABCD);

      exec(mk(4'h0, 4'h1, 4'h1, 4'h0, 16'h0003, 16'h0005, 16'h0, 0, 1, 0, 0, 0, 0), 0, "sub");
      chk("sub alu", alu_result_MEM, 16'hFFFE);
      exec(mk(4'h0, 4'h2, 4'h1, 4'h0, 16'hF0F0, 16'h3C3C, 16'h0, 0, 1, 0, 0, 0, 0), 0, "and");
      exec(mk(4'h0, 4'h3, 4'h1, 4'h0, 16'hF0F0, 16'h3C3C, 16'h0, 0, 1, 0, 0, 0, 0), 0, "or");
      exec(mk(4'h0, 4'h0, 4'h1, 4'h0, 16'h1111, 16'h0020, 16'h0007, 1, 1, 0, 0, 0, 0), 0, "add_imm");
      chk("add_imm alu", alu_result_MEM, 16'h0027);
      exec(mk(4'h0, 4'h8, 4'h1, 4'h1, 16'h8001, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0), 0, "sll");
      chk("sll alu", alu_result_MEM, 16'h0002);
      exec(mk(4'h0, 4'h9, 4'h1, 4'h4, 16'h8001, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0), 0, "srl");
      chk("srl alu", alu_result_MEM, 16'h0800);
      exec(mk(4'h0, 4'hA, 4'h1, 4'h1, 16'h8001, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0), 0, "rol");
      chk("rol alu", alu_result_MEM, 16'h0003);
      exec(mk(4'h0, 4'hB, 4'h1, 4'h1, 16'h8001, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0), 0, "ror");
      chk("ror alu", alu_result_MEM, 16'hC000);
      exec(mk(4'h0, 4'h6, 4'h1, 4'h0, 16'h1234, 16'h5678, 16'h0, 0, 1, 1, 0, 0, 0), 0, "badfn");
      chk("badfn writes", {alu_result_MEM, regWrite_MEM, r0Write_MEM}, 0);

      exec(mul1, 17, "mul");
      chk("mul lo", alu_result_MEM, 16'hFFF1);
      chk("mul hi", r0_result_MEM, 16'hFFFF);
      chk("mul r0w", r0Write_MEM, 1);
      exec(mk(4'h0, 4'h5, 4'h2, 4'h0, 16'hFFF9, 16'h0002, 16'h0, 0, 1, 1, 0, 0, 0), 17, "div");
      chk("div q", alu_result_MEM, 16'hFFFD);
      chk("div r", r0_result_MEM, 16'hFFFF);
      exec(mk(4'h0, 4'h5, 4'h2, 4'h0, 16'h0011, 16'h0000, 16'h0, 0, 1, 1, 0, 0, 0), 17, "div0");
      chk("div0 q", alu_result_MEM, 16'hFFFF);
      chk("div0 r", r0_result_MEM, 16'h0011);
      chk("div0 flag", div_zero_MEM, 1);
      exec(mk(4'h0, 4'h5, 4'h2, 4'h0, 16'h8000, 16'hFFFF, 16'h0, 0, 1, 1, 0, 0, 0), 17, "divovf");
      chk("divovf q", alu_result_MEM, 16'h8000);
      chk("divovf r/flag", {r0_result_MEM, div_zero_MEM}, 0);
      exec(mk(4'h0, 4'h4, 4'h2, 4'h0, 16'h8000, 16'h8000, 16'h0, 0, 1, 1, 0, 0, 0), 17, "mulmin");
      exec(mk(4'h0, 4'h5, 4'h2, 4'h0, 16'h0064, 16'hFFF9, 16'h0, 0, 1, 1, 0, 0, 0), 17, "divneg");
      exec(nop, 0, "nop2");

      flush_idle(mk(4'h0, 4'h0, 4'h3, 4'h0, 16'h0001, 16'h0001, 16'h0, 0, 1, 0, 0, 0, 0), "flush_add");
      flush_idle(mul1, "flush_mul_idle");
      exec(nop, 0, "nop3");

      abort_busy(mul1, 1'b0, "flush_busy");
      exec(nop, 0, "after_flush");
      abort_busy(mul1, 1'b1, "reset_busy");
      exec(nop, 0, "after_reset");

      flush_done(mul1, "flush_done");
      exec(nop, 0, "after_flush_done");
      exec(mul1, 17, "mul_again");

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline; consumes the ID/EX bundle (*_EX signals) produced by the fetch/decode front end.
- Performs single-cycle ALU ops, load/store address generation, and iterative signed MUL/DIV.
- Drives stall_ex back upstream to freeze IF/ID/EX while a MUL/DIV is in flight.
- Registers results into the EX/MEM pipeline register (*_MEM outputs).

Parameters:
- DATA_W, 16, datapath width; MUL/DIV iteration count equals DATA_W.
- RA_W, 4, register-address, opcode and function-field width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- flush_ex  in  1  kill the instruction currently in EX.
- RD1_EX, RD2_EX, SE_offset_EX  in  16  operand A (Rd data), operand B (Rs data), sign-extended immediate.
- opcode_EX, RA1_EX, RA2_EX, FN_offset_EX  in  4  opcode, Rd address, Rs address, function code.
- regWrite_EX, r0Write_EX, alusource_EX, memRead_EX, memWrite_EX, memSource_EX  in  1  decoded controls.
- stall_ex  out  1  freeze upstream stages and hold all *_EX inputs stable.
- alu_result_MEM  out  16  ALU result or memory address.
- r0_result_MEM  out  16  MUL high half or DIV remainder.
- store_data_MEM  out  16  RD1 for stores.
- RA1_MEM  out  4  destination register.
- regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM  out  1  forwarded controls.
- div_zero_MEM  out  1  divide by zero occurred.

Behaviour:
- Reset: all *_MEM outputs 0, stall_ex 0, FSM to IDLE, iteration counter 0.
- Operand select:
  - alusource=0: A=RD1, B=RD2.
  - alusource=1: A=RD2, B=SE_offset.
  - LW/SW: address = RD2 + SE_offset, mod 2^16.
- R-type (opcode 0000), FN field:
  - 0 ADD, 1 SUB: wrap, no flags.
  - 2 AND, 3 OR.
  - 4 MUL, 5 DIV: signed, multi-cycle.
  - 8 SLL, 9 SRL, A ROL, B ROR: shift amount = RA2_EX used as an immediate.
  - Undefined FN: result 0, no writes.
- Other opcodes:
  - LW (1000) and SW (1011) compute the address.
  - All others pass controls through; alu_result = A + B.
- Single-cycle ops: EX/MEM captures the result and controls at the next rising edge (latency 1).
- MUL/DIV FSM, states IDLE, BUSY, DONE:
  - IDLE with MUL/DIV present and no flush: stall_ex=1; latch operand magnitudes and result sign; counter=0; go to BUSY.
  - BUSY: stall_ex=1; one shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter increments; at counter==DATA_W-1 go to DONE.
  - DONE: stall_ex=0; apply sign correction; EX/MEM captures the result at this edge; go to IDLE.
  - Total: stall_ex high 17 cycles; instruction resident in EX for 18 cycles.
  - EX/MEM loads a bubble (all write/mem enables 0) on every edge while stall_ex=1.
- MUL: signed 32-bit product; low half to alu_result_MEM (regWrite), high half to r0_result_MEM (r0Write).
- DIV: quotient truncated toward zero to alu_result_MEM; remainder takes the sign of the dividend, to r0_result_MEM.
- Divide by zero: quotient 0xFFFF, remainder = dividend, div_zero_MEM=1 for that instruction. div_zero_MEM is 0 for every other instruction.
- -32768 / -1: quotient 0x8000, remainder 0; no flag.
- flush_ex:
  - In IDLE: a bubble is loaded into EX/MEM.
  - In BUSY or DONE: abort to IDLE; stall_ex drops the next cycle; a bubble is loaded.
- flush_ex has priority over MUL/DIV start.
- reset mid-MUL/DIV: immediate return to IDLE with outputs cleared.
- After DONE the FSM returns to IDLE. A back-to-back MUL/DIV starts its own IDLE->BUSY sequence the cycle after DONE.

Decomposition:
- Shared package/include holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW);
  - FN constants (FN_ADD … FN_ROR);
  - FSM state encodings;
  - DATA_W.
- One sub-module: ex_muldiv, the iterative signed multiply/divide FSM with start, op, a, b, busy, done, lo, hi and dz ports.
- ex_stage holds the ALU, operand mux and EX/MEM register.

Test Plan:
- Reset held 2 cycles with random inputs -> all *_MEM outputs 0 and stall_ex 0.
- ADD, RD1=0x7FFF, RD2=0x0001, RA1=3 -> next edge alu_result_MEM=0x8000, RA1_MEM=3, regWrite_MEM=1.
- LW, alusource=1, RD2=0x0010, SE_offset=0xFFFE -> alu_result_MEM=0x000E, memRead_MEM=1, regWrite_MEM=1.
- MUL, RD1=0xFFFD, RD2=0x0005:
  - stall_ex high for exactly 17 cycles with bubbles in EX/MEM;
  - then alu_result_MEM=0xFFF1, r0_result_MEM=0xFFFF, r0Write_MEM=1.
- DIV cases:
  - 0xFFF9 / 0x0002 -> quotient 0xFFFD, remainder 0xFFFF.
  - 0x0011 / 0x0000 -> quotient 0xFFFF, remainder 0x0011, div_zero_MEM=1.
- MUL flushed in BUSY cycle 5 -> stall_ex low the next cycle, no register or R0 write. Repeat with reset instead of flush -> same result.
